usb_rx_frame_buffer: RTL and testbench
======================================

// Module: usb_rx_frame_buffer
// PURPOSE
//  Downstream neighbour of the FX2LP slave-FIFO reader. Buffers 16-bit words read from EP2 (OUT FIFO),
//  groups them into fixed-length frames, and releases a frame to the convolution engine only once the
//  whole frame is stored. Streams over valid/ready with a last-word marker. Never underruns mid-frame.
// PARAMETERS
//  DATA_W       16   word width; matches FD
//  DEPTH        8    buffer depth in words; power of 2; DEPTH >= FRAME_WORDS
//  FRAME_WORDS  4    words per frame
//  ADDR_W       $clog2(DEPTH)  pointer width; derived, not overridden
// PORTS
//  CLKOUT       in   1          FX2LP CLKOUT domain clock; all logic on posedge
//  rst_n        in   1          asynchronous active-low reset
//  clear        in   1          synchronous flush of all contents and state
//  in_valid     in   1          word on in_data captured this cycle (USB reader SLRD strobe)
//  in_data      in   DATA_W     word read from FD
//  in_ready     out  1          space available; USB reader must not strobe SLRD while low
//  out_valid    out  1          out_data holds a valid word of the current frame
//  out_data     out  DATA_W     word to conv engine
//  out_last     out  1          out_data is the final word of the frame
//  out_ready    in   1          conv engine accepts the word
//  frame_ready  out  1          at least one complete frame buffered
//  overflow     out  1          sticky: a word arrived while full and was dropped
//  level        out  ADDR_W+1   words currently stored
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous): pointers, level, counters cleared; state IDLE.
//   in_ready=1, out_valid=0, out_last=0, frame_ready=0, overflow=0, level=0.
//  Write: accepted when in_valid && in_ready. Stored at wr_ptr. wr_ptr wraps modulo DEPTH.
//   in_word_cnt counts 0..FRAME_WORDS-1. A write at count FRAME_WORDS-1 wraps it to 0 and increments frame_cnt.
//  Full: level==DEPTH -> in_ready=0. in_valid while full drops the word, sets overflow, leaves level unchanged.
//  Read FSM, 2 states:
//   IDLE: out_valid=0. Go to STREAM when frame_cnt!=0.
//   STREAM: out_valid=1; out_data=mem[rd_ptr] (combinational read of the register array).
//    out_last=1 when out_word_cnt==FRAME_WORDS-1.
//    On out_valid && out_ready: rd_ptr++ (wraps), out_word_cnt++, next word presented the next cycle (no bubble).
//    Handshake on the last word: out_word_cnt<=0, frame_cnt--, go to IDLE.
//    Exactly one IDLE cycle separates frames.
//  out_valid held and out_data stable while out_ready=0 (no retraction).
//  Latency: write completing a frame in cycle N -> frame_ready=1 in N+1 -> out_valid=1 in N+2.
//  level: +1 on accepted write, -1 on read handshake, unchanged when both occur in the same cycle.
//  frame_cnt: same rule; simultaneous frame completion and last-word read leave it unchanged.
//  frame_ready = (frame_cnt != 0). Partial frames are never streamed.
//  clear: highest priority; overrides a same-cycle write or read.
//   Next cycle: pointers, counters, level=0, frame_cnt=0, overflow=0, state IDLE.
//  rst_n asserted mid-STREAM: immediate return to reset values; buffered data is discarded.
// STRUCTURE
//  Shared package usb_pkg: DATA_W constant; FSM state encoding (IDLE, STREAM) as localparams.
//  Sub-module usb_word_ram:
//   DEPTH x DATA_W register array, write port, combinational read port, wr/rd pointers, level.
//  Top level holds the frame counters, read FSM, and overflow/clear logic.
// TESTING (bench: DEPTH=8, FRAME_WORDS=4)
//  1. Reset: pulse rst_n low mid-STREAM.
//     -> out_valid=0, level=0, frame_ready=0, in_ready=1 with no clock edge.
//  2. Write 0x0001..0x0004 back-to-back, out_ready=1.
//     -> out_valid at N+2; data 1,2,3,4 on consecutive cycles; out_last only with 0x0004; frame_ready back to 0.
//  3. Write 3 words only.
//     -> level=3, frame_ready=0, out_valid stays 0 for 20 cycles.
//  4. out_ready=0, write 8 words, then a 9th.
//     -> in_ready=0 after the 8th; overflow=1; level=8; frame_cnt=2.
//     -> Release out_ready: 8 words out, out_last twice, one IDLE gap.
//  5. 4th word of frame 2 written in the same cycle as the last-word handshake of frame 1.
//     -> frame_cnt stays 1, level unchanged, frame 2 streams after one IDLE cycle.
//  6. clear asserted in STREAM together with in_valid.
//     -> next cycle level=0, overflow=0, out_valid=0, frame_ready=0; the word is dropped.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared constants for the USB receive path: word width and read-FSM encoding.
package usb_pkg;

    localparam int DATA_W = 16;

    typedef logic [0:0] rd_state_t;
    localparam rd_state_t ST_IDLE   = 1'b0;
    localparam rd_state_t ST_STREAM = 1'b1;

endpackage

// File: rtl/usb_rx_frame_buffer_if.sv
// Handshake bundle between the FX2LP reader, the frame buffer and the convolution engine.
// valid/ready: a word transfers on a cycle where valid && ready; the sender holds valid and data until then.
interface usb_rx_frame_buffer_if #(
    parameter int DATA_W = usb_pkg::DATA_W
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;

    // The buffer itself
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    // Reader and consumer side together
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/usb_word_ram.sv
// Circular word store: register array with combinational read, wrapping pointers and fill level.
module usb_word_ram #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLKOUT,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   level,
    output logic              full
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q,  level_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_en) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            // Simultaneous write and read leave the level unchanged
            case ({wr_en, rd_en})
                2'b10:   level_d = level_q + (ADDR_W+1)'(1);
                2'b01:   level_d = level_q - (ADDR_W+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge CLKOUT or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;
    assign full    = (level_q == (ADDR_W+1)'(DEPTH));

endmodule

// File: rtl/usb_rx_frame_buffer.sv
// Frame buffer between the FX2LP EP2 reader and the convolution engine: stores words and
// releases them only as whole frames, with a last-word marker and one idle cycle between frames.
module usb_rx_frame_buffer
    import usb_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int FRAME_WORDS = 4,
    parameter int ADDR_W      = $clog2(DEPTH)
) (
    input  logic                CLKOUT,
    input  logic                rst_n,
    input  logic                clear,
    usb_rx_frame_buffer_if.slave bus,
    output logic                frame_ready,
    output logic                overflow,
    output logic [ADDR_W:0]     level,
    output rd_state_t           dbg_state,
    output logic [ADDR_W:0]     dbg_frame_cnt
);

    localparam int CNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_WORDS - 1);

    rd_state_t        state_q, state_d;
    logic [CNT_W-1:0] in_word_cnt_q,  in_word_cnt_d;
    logic [CNT_W-1:0] out_word_cnt_q, out_word_cnt_d;
    logic [ADDR_W:0]  frame_cnt_q,    frame_cnt_d;
    logic             overflow_q,     overflow_d;

    logic              full;
    logic              wr_en;
    logic              rd_en;
    logic              frame_complete;
    logic              frame_done;
    logic [DATA_W-1:0] rd_data;

    // clear wins over any same-cycle transfer, so neither side sees a handshake take effect
    assign wr_en          = bus.in_valid && !full && !clear;
    assign rd_en          = bus.out_valid && bus.out_ready && !clear;
    assign frame_complete = wr_en && (in_word_cnt_q == CNT_LAST);
    assign frame_done     = rd_en && bus.out_last;

    usb_word_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .CLKOUT  (CLKOUT),
        .rst_n   (rst_n),
        .clear   (clear),
        .wr_en   (wr_en),
        .wr_data (bus.in_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .level   (level),
        .full    (full)
    );

    always_comb begin
        in_word_cnt_d  = in_word_cnt_q;
        out_word_cnt_d = out_word_cnt_q;
        frame_cnt_d    = frame_cnt_q;
        overflow_d     = overflow_q;
        if (clear) begin
            in_word_cnt_d  = '0;
            out_word_cnt_d = '0;
            frame_cnt_d    = '0;
            overflow_d     = 1'b0;
        end else begin
            if (bus.in_valid && full) begin
                overflow_d = 1'b1;
            end
            if (wr_en) begin
                in_word_cnt_d = (in_word_cnt_q == CNT_LAST) ? '0 : in_word_cnt_q + CNT_W'(1);
            end
            if (rd_en) begin
                out_word_cnt_d = (out_word_cnt_q == CNT_LAST) ? '0 : out_word_cnt_q + CNT_W'(1);
            end
            case ({frame_complete, frame_done})
                2'b10:   frame_cnt_d = frame_cnt_q + (ADDR_W+1)'(1);
                2'b01:   frame_cnt_d = frame_cnt_q - (ADDR_W+1)'(1);
                default: frame_cnt_d = frame_cnt_q;
            endcase
        end
    end

    always_ff @(posedge CLKOUT or negedge rst_n) begin
        if (!rst_n) begin
            in_word_cnt_q  <= '0;
            out_word_cnt_q <= '0;
            frame_cnt_q    <= '0;
            overflow_q     <= 1'b0;
        end else begin
            in_word_cnt_q  <= in_word_cnt_d;
            out_word_cnt_q <= out_word_cnt_d;
            frame_cnt_q    <= frame_cnt_d;
            overflow_q     <= overflow_d;
        end
    end

    // Read FSM: state register
    always_ff @(posedge CLKOUT or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read FSM: next state; leaving STREAM always costs one IDLE cycle before the next frame
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (frame_cnt_q != '0) state_d = ST_STREAM;
                ST_STREAM: if (frame_done)        state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Read FSM: outputs
    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        if (state_q == ST_STREAM) begin
            bus.out_valid = 1'b1;
            bus.out_last  = (out_word_cnt_q == CNT_LAST);
        end
    end

    assign bus.out_data   = rd_data;
    assign bus.in_ready   = !full;
    assign frame_ready    = (frame_cnt_q != '0);
    assign overflow       = overflow_q;
    assign dbg_state      = state_q;
    assign dbg_frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_usb_rx_frame_buffer.sv
// Bench for usb_rx_frame_buffer: directed scenarios plus random traffic against a word-queue model.
module tb_usb_rx_frame_buffer;
    import usb_pkg::*;

    localparam int DEPTH = 8;
    localparam int FW    = 4;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       frame_ready;
    logic       overflow;
    logic [3:0] level;
    rd_state_t  dbg_state;
    logic [3:0] dbg_frame_cnt;

    usb_rx_frame_buffer_if #(.DATA_W(DATA_W)) bus ();

    usb_rx_frame_buffer #(
        .DEPTH       (DEPTH),
        .FRAME_WORDS (FW)
    ) dut (
        .CLKOUT        (clk),
        .rst_n         (rst_n),
        .clear         (clear),
        .bus           (bus),
        .frame_ready   (frame_ready),
        .overflow      (overflow),
        .level         (level),
        .dbg_state     (dbg_state),
        .dbg_frame_cnt (dbg_frame_cnt)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: stored words in arrival order, running totals since the last flush
    logic [DATA_W-1:0] exp_q[$];
    int  wr_total;
    int  rd_total;
    bit  m_stream;
    bit  m_ovf;

    function automatic int m_frames();
        return (wr_total / FW) - (rd_total / FW);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        wr_total = 0;
        rd_total = 0;
        m_stream = 1'b0;
        m_ovf    = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("out_valid",   32'(bus.out_valid), 32'(m_stream));
        check("in_ready",    32'(bus.in_ready),  32'(exp_q.size() < DEPTH));
        check("level",       32'(level),         32'(exp_q.size()));
        check("frame_ready", 32'(frame_ready),   32'(m_frames() != 0));
        check("frame_cnt",   32'(dbg_frame_cnt), 32'(m_frames()));
        check("overflow",    32'(overflow),      32'(m_ovf));
        if (m_stream && exp_q.size() > 0) begin
            check("out_data", 32'(bus.out_data), 32'(exp_q[0]));
            check("out_last", 32'(bus.out_last), 32'((rd_total % FW) == FW - 1));
        end else begin
            check("out_last_idle", 32'(bus.out_last), 32'(0));
        end
    endtask

    task automatic model_step(input bit iv, input logic [DATA_W-1:0] id, input bit ordy, input bit clr);
        bit full_now;
        bit acc_r;
        bit last_r;
        int frames_now;
        full_now   = (exp_q.size() == DEPTH);
        frames_now = m_frames();
        if (clr) begin
            model_reset();
        end else begin
            acc_r  = m_stream && ordy;
            last_r = acc_r && ((rd_total % FW) == FW - 1);
            if (iv && full_now) m_ovf = 1'b1;
            if (acc_r) begin
                void'(exp_q.pop_front());
                rd_total++;
            end
            if (iv && !full_now) begin
                exp_q.push_back(id);
                wr_total++;
            end
            if (m_stream) m_stream = !last_r;
            else          m_stream = (frames_now != 0);
        end
    endtask

    // driver: inputs set and outputs checked on the falling edge, model advanced on the rising edge
    task automatic step(input bit iv, input logic [DATA_W-1:0] id, input bit ordy, input bit clr);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        clear         = clr;
        check_outputs();
        @(posedge clk);
        model_step(iv, id, ordy, clr);
    endtask

    task automatic flush();
        step(1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        clear         = 1'b0;
        rst_n         = 1'b0;
        model_reset();
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'(0));
        check("rst_in_ready",  32'(bus.in_ready),  32'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset in the middle of a frame being streamed
        for (int i = 0; i < FW; i++) step(1'b1, 16'h00a0 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)  step(1'b0, '0, 1'b0, 1'b0);
        check("pre_rst_stream", 32'(bus.out_valid), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_out_valid",   32'(bus.out_valid), 32'(0));
        check("arst_level",       32'(level),         32'(0));
        check("arst_frame_ready", 32'(frame_ready),   32'(0));
        check("arst_in_ready",    32'(bus.in_ready),  32'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // One frame back-to-back with the consumer always ready
        for (int i = 1; i <= FW; i++) step(1'b1, 16'(i), 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)   step(1'b0, '0, 1'b1, 1'b0);

        // Partial frame must never stream
        for (int i = 0; i < 3; i++)  step(1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0);
        flush();

        // Fill to full with the consumer stalled, then one more word to overflow
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 14; i++)        step(1'b0, '0, 1'b1, 1'b0);
        flush();

        // Frame-2 completion coincides with frame-1 last-word handshake
        for (int i = 0; i < FW + 3; i++) step(1'b1, 16'h0300 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < FW - 1; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 16'h03ff, 1'b1, 1'b0);
        check("coincide_frame_cnt", 32'(wr_total / FW - rd_total / FW), 32'(1));
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);

        // clear while streaming, together with a write
        for (int i = 0; i < FW; i++) step(1'b1, 16'h0400 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 2; i++)  step(1'b1, 16'h0410, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 16'h0420, 1'b0, 1'b0);
        step(1'b1, 16'h0430, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 99) == 0));
        end
        for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
